// File: rtl/periph_pkg.sv
// Shared layout of one peripheral bundle (50 bits, LED_D at the MSB end, LCD_D at the LSB end),
// its idle value, the switch FSM states and the select-width helper.
package periph_pkg;

  localparam int LCD_D_W    = 8;
  localparam int LCD_E_W    = 1;
  localparam int LCD_RW_W   = 1;
  localparam int LCD_RS_W   = 1;
  localparam int DOT_RD_W   = 7;
  localparam int DOT_CD_W   = 10;
  localparam int SEG_DATA_W = 8;
  localparam int SEG_COM_W  = 6;
  localparam int LED_D_W    = 8;

  localparam int LCD_D_OFF    = 0;
  localparam int LCD_E_OFF    = LCD_D_OFF + LCD_D_W;
  localparam int LCD_RW_OFF   = LCD_E_OFF + LCD_E_W;
  localparam int LCD_RS_OFF   = LCD_RW_OFF + LCD_RW_W;
  localparam int DOT_RD_OFF   = LCD_RS_OFF + LCD_RS_W;
  localparam int DOT_CD_OFF   = DOT_RD_OFF + DOT_RD_W;
  localparam int SEG_DATA_OFF = DOT_CD_OFF + DOT_CD_W;
  localparam int SEG_COM_OFF  = SEG_DATA_OFF + SEG_DATA_W;
  localparam int LED_D_OFF    = SEG_COM_OFF + SEG_COM_W;
  localparam int BUNDLE_W     = LED_D_OFF + LED_D_W;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [LED_D_W-1:0]    led_d;
    logic [SEG_COM_W-1:0]  seg_com;
    logic [SEG_DATA_W-1:0] seg_data;
    logic [DOT_CD_W-1:0]   dot_cd;
    logic [DOT_RD_W-1:0]   dot_rd;
    logic                  lcd_rs;
    logic                  lcd_rw;
    logic                  lcd_e;
    logic [LCD_D_W-1:0]    lcd_d;
  } bundle_t;

  localparam bundle_t IDLE_BUNDLE = '0;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_WAIT_E = 2'd1,
    ST_BLANK  = 2'd2
  } sw_state_e;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_bundle_mux.sv
// Combinational N_SRC-to-1 bundle selector; an out-of-range index yields the idle bundle,
// and exactly one source (or none) is ever chosen, so bits of two sources never mix.
module periph_bundle_mux
  import periph_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int SW    = 1
) (
  input  logic [N_SRC*BUNDLE_W-1:0] src_bus_i,
  input  logic [SW-1:0]             sel_i,
  output bundle_t                   bundle_o
);

  bundle_t src_arr [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_split
    assign src_arr[gi] = src_bus_i[gi*BUNDLE_W +: BUNDLE_W];
  end

  always_comb begin
    bundle_o = IDLE_BUNDLE;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_i == SW'(k)) bundle_o = src_arr[k];
    end
  end

endmodule

// File: rtl/periph_src_switch.sv
// Glitch-safe switch of the peripheral pins between N_SRC driving sources: waits for the
// outgoing LCD_E to drop (bounded), blanks all pins for BLANK_CYC cycles, then hands over.
module periph_src_switch
  import periph_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int BLANK_CYC = 16,
  parameter int E_TIMEOUT = 255,
  localparam int SW       = sel_width(N_SRC)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [SW-1:0]             SEL,
  input  logic [N_SRC*BUNDLE_W-1:0] SRC_BUS,
  output logic [7:0]                LED_D,
  output logic [5:0]                SEG_COM,
  output logic [7:0]                SEG_DATA,
  output logic [9:0]                DOT_CD,
  output logic [6:0]                DOT_RD,
  output logic                      LCD_RS,
  output logic                      LCD_RW,
  output logic                      LCD_E,
  output logic [7:0]                LCD_D,
  output logic [SW-1:0]             CUR_SEL,
  output logic                      BUSY,
  output logic                      SEL_ERR
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_TIMEOUT - 1);
  localparam logic [SW:0]      N_SRC_V    = (SW + 1)'(N_SRC);

  sw_state_e        state_q, state_d;
  logic [SW-1:0]    cur_sel_q, cur_sel_d;
  logic [SW-1:0]    nxt_sel_q, nxt_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             force_q, force_d;
  logic             sel_err_q;
  bundle_t          out_q, out_d;
  bundle_t          mux_bundle;
  logic [SW-1:0]    mux_sel;
  logic             sel_valid;

  assign sel_valid = ({1'b0, SEL} < N_SRC_V);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // During BLANK the mux already looks at the incoming source so the handover edge loads it.
  assign mux_sel   = (state_q == ST_BLANK) ? nxt_sel_q : cur_sel_q;

  periph_bundle_mux #(
    .N_SRC (N_SRC),
    .SW    (SW)
  ) u_mux (
    .src_bus_i (SRC_BUS),
    .sel_i     (mux_sel),
    .bundle_o  (mux_bundle)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ACTIVE;
      cur_sel_q <= '0;
      nxt_sel_q <= '0;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      sel_err_q <= 1'b0;
      out_q     <= IDLE_BUNDLE;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      nxt_sel_q <= nxt_sel_d;
      cnt_q     <= cnt_d;
      force_q   <= force_d;
      sel_err_q <= !sel_valid;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    nxt_sel_d = nxt_sel_q;
    cnt_d     = cnt_q;
    force_d   = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (sel_valid && (SEL != cur_sel_q)) begin
          state_d   = ST_WAIT_E;
          nxt_sel_d = SEL;
          cnt_d     = '0;
        end
      end
      ST_WAIT_E: begin
        cnt_d = cnt_inc;
        if (sel_valid && (SEL != nxt_sel_q)) nxt_sel_d = SEL;
        if (sel_valid && (SEL == cur_sel_q)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (force_q || !mux_bundle.lcd_e) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else if (cnt_q >= E_LAST) begin
          force_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (sel_valid && (SEL != nxt_sel_q)) begin
          nxt_sel_d = SEL;
          cnt_d     = '0;
        end else if (cnt_q >= BLANK_LAST) begin
          state_d   = ST_ACTIVE;
          cur_sel_d = nxt_sel_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // A timed-out source gets one cycle with LCD_E pulled low and everything else frozen.
  always_comb begin
    out_d = mux_bundle;
    if (force_d) begin
      out_d       = out_q;
      out_d.lcd_e = 1'b0;
    end else if (state_d == ST_BLANK) begin
      out_d = IDLE_BUNDLE;
    end
  end

  assign BUSY     = (state_q != ST_ACTIVE);
  assign SEL_ERR  = sel_err_q;
  assign CUR_SEL  = cur_sel_q;
  assign LED_D    = out_q.led_d;
  assign SEG_COM  = out_q.seg_com;
  assign SEG_DATA = out_q.seg_data;
  assign DOT_CD   = out_q.dot_cd;
  assign DOT_RD   = out_q.dot_rd;
  assign LCD_RS   = out_q.lcd_rs;
  assign LCD_RW   = out_q.lcd_rw;
  assign LCD_E    = out_q.lcd_e;
  assign LCD_D    = out_q.lcd_d;

endmodule

// File: tb/tb_periph_src_switch.sv
// Scoreboard bench: stimulus pushes per-cycle expected pins/status for a 2-source and a
// 3-source instance; a negedge monitor pops and compares against the DUT outputs.
module tb_periph_src_switch;

  localparam int BW = 50;

  typedef struct {
    int         cyc;
    int         which;
    int         tag;
    logic [BW-1:0] pins;
    logic [2:0] cur;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic [0:0]    sel2;
  logic [2*BW-1:0] bus2;
  logic [1:0]    sel3;
  logic [3*BW-1:0] bus3;

  logic [7:0] led2, sdat2, lcdd2, led3, sdat3, lcdd3;
  logic [5:0] scom2, scom3;
  logic [9:0] dcd2, dcd3;
  logic [6:0] drd2, drd3;
  logic       rs2, rw2, e2, rs3, rw3, e3;
  logic [0:0] cur2;
  logic [1:0] cur3;
  logic       busy2, err2, busy3, err3;
  logic [BW-1:0] pins2, pins3;

  assign pins2 = {led2, scom2, sdat2, dcd2, drd2, rs2, rw2, e2, lcdd2};
  assign pins3 = {led3, scom3, sdat3, dcd3, drd3, rs3, rw3, e3, lcdd3};

  periph_src_switch #(.N_SRC(2), .BLANK_CYC(16), .E_TIMEOUT(255)) dut2 (
    .CLK(clk), .RST(rst), .SEL(sel2), .SRC_BUS(bus2),
    .LED_D(led2), .SEG_COM(scom2), .SEG_DATA(sdat2), .DOT_CD(dcd2), .DOT_RD(drd2),
    .LCD_RS(rs2), .LCD_RW(rw2), .LCD_E(e2), .LCD_D(lcdd2),
    .CUR_SEL(cur2), .BUSY(busy2), .SEL_ERR(err2)
  );

  periph_src_switch #(.N_SRC(3), .BLANK_CYC(16), .E_TIMEOUT(255)) dut3 (
    .CLK(clk), .RST(rst), .SEL(sel3), .SRC_BUS(bus3),
    .LED_D(led3), .SEG_COM(scom3), .SEG_DATA(sdat3), .DOT_CD(dcd3), .DOT_RD(drd3),
    .LCD_RS(rs3), .LCD_RW(rw3), .LCD_E(e3), .LCD_D(lcdd3),
    .CUR_SEL(cur3), .BUSY(busy3), .SEL_ERR(err3)
  );

  function automatic logic [BW-1:0] mk(input logic [7:0] led, input logic [7:0] lcdd, input logic e);
    logic [5:0] scom;
    logic [9:0] dcd;
    logic [6:0] drd;
    scom = led[5:0] ^ 6'h2A;
    dcd  = {2'b10, ~led};
    drd  = lcdd[6:0] ^ 7'h13;
    return {led, scom, led ^ 8'hF0, dcd, drd, 1'b1, 1'b0, e, lcdd};
  endfunction

  // Monitor / scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic finish_req = 1'b0;
  logic mon_done = 1'b0;
  exp_t e_cur;
  logic [BW-1:0] a_pins;
  logic [2:0] a_cur;
  logic a_busy, a_err;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_cur = sb.pop_front();
      if (e_cur.which == 0) begin
        a_pins = pins2; a_cur = {2'b00, cur2}; a_busy = busy2; a_err = err2;
      end else begin
        a_pins = pins3; a_cur = {1'b0, cur3}; a_busy = busy3; a_err = err3;
      end
      n_checks++;
      if ({a_pins, a_cur, a_busy, a_err} !== {e_cur.pins, e_cur.cur, e_cur.busy, e_cur.err}) begin
        n_fail++;
        $display("FAIL dut%0d step%0d cyc%0d: got pins=%h cur=%0d busy=%b err=%b, want pins=%h cur=%0d busy=%b err=%b",
                 (e_cur.which == 0) ? 2 : 3, e_cur.tag, e_cur.cyc, a_pins, a_cur, a_busy, a_err,
                 e_cur.pins, e_cur.cur, e_cur.busy, e_cur.err);
      end
    end
    if (finish_req && !mon_done) begin
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d unchecked entries, want 0", sb.size());
      end
      mon_done = 1'b1;
    end
  end

  int tag_cnt = 0;

  task automatic tick(input int which, input logic [BW-1:0] p, input int cur, input logic busy, input logic err);
    exp_t e;
    e.cyc = cyc + 1; e.which = which; e.tag = tag_cnt;
    e.pins = p; e.cur = 3'(cur); e.busy = busy; e.err = err;
    sb.push_back(e);
    tag_cnt++;
    @(posedge clk);
    #2;
  endtask

  logic [BW-1:0] b0, b0b, b1, b1e0, c0, c1, c2;
  logic [BW-1:0] zero;

  initial begin
    zero = '0;
    b0   = mk(8'hA5, 8'h81, 1'b0);
    b0b  = mk(8'hA5, 8'h42, 1'b0);
    b1   = mk(8'h3C, 8'h5A, 1'b1);
    b1e0 = mk(8'h3C, 8'h5A, 1'b0);
    c0   = mk(8'h11, 8'h22, 1'b0);
    c1   = mk(8'h33, 8'h44, 1'b0);
    c2   = mk(8'h55, 8'h66, 1'b1);

    rst = 1'b1; sel2 = 1'b0; sel3 = 2'd0;
    bus2 = {b1, b0};
    bus3 = {c2, c1, c0};

    // reset: idle pins, not busy, no error
    tick(0, zero, 0, 0, 0);
    tick(0, zero, 0, 0, 0);
    rst = 1'b0;
    // steady source 0, latency 1
    tick(0, b0, 0, 0, 0);
    tick(0, b0, 0, 0, 0);
    bus2 = {b1, b0b};
    tick(0, b0b, 0, 0, 0);
    bus2 = {b1, b0};
    tick(0, b0, 0, 0, 0);
    // 0 -> 1, source 0 LCD_E already low
    sel2 = 1'b1;
    tick(0, b0, 0, 1, 0);
    for (int i = 0; i < 16; i++) tick(0, zero, 0, 1, 0);
    tick(0, b1, 1, 0, 0);
    tick(0, b1, 1, 0, 0);
    // 1 -> 0, source 1 holds LCD_E high: timeout path
    sel2 = 1'b0;
    for (int i = 0; i < 255; i++) tick(0, b1, 1, 1, 0);
    tick(0, b1e0, 1, 1, 0);
    for (int i = 0; i < 16; i++) tick(0, zero, 1, 1, 0);
    tick(0, b0, 0, 0, 0);

    // three-source instance, steady on source 0
    tick(1, c0, 0, 0, 0);
    // reset in the middle of blanking
    sel3 = 2'd1;
    tick(1, c0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, zero, 0, 1, 0);
    rst = 1'b1;
    tick(1, zero, 0, 0, 0);
    rst = 1'b0;
    tick(1, c0, 0, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, zero, 0, 1, 0);
    tick(1, c1, 1, 0, 0);
    // back to 0
    sel3 = 2'd0;
    tick(1, c1, 1, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, zero, 1, 1, 0);
    tick(1, c0, 0, 0, 0);
    // 0 -> 1, retarget to 2 at blank cycle 10
    sel3 = 2'd1;
    tick(1, c0, 0, 1, 0);
    for (int i = 0; i < 11; i++) tick(1, zero, 0, 1, 0);
    sel3 = 2'd2;
    for (int i = 0; i < 16; i++) tick(1, zero, 0, 1, 0);
    tick(1, c2, 2, 0, 0);
    // out-of-range select ignored, error pulse each cycle
    sel3 = 2'd3;
    for (int i = 0; i < 4; i++) tick(1, c2, 2, 0, 1);
    sel3 = 2'd2;
    tick(1, c2, 2, 0, 0);
    // abort during WAIT_E (source 2 holds LCD_E high)
    sel3 = 2'd0;
    tick(1, c2, 2, 1, 0);
    sel3 = 2'd2;
    tick(1, c2, 2, 0, 0);
    tick(1, c2, 2, 0, 0);

    finish_req = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_done: got 0, want 1");
      $fatal(1, "monitor did not finish");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/periph_src_switch.md
PERIPH_SRC_SWITCH -- requirements
Module: periph_src_switch

Interface
REQ-001 Parameter N_SRC, default 2: number of peripheral-driving sources, legal range 2..8.
REQ-002 Parameter BLANK_CYC, default 16: idle-blanking cycles inserted on every source change, legal range 1..255.
REQ-003 Parameter E_TIMEOUT, default 255: maximum cycles spent waiting for the outgoing source's LCD_E to drop.
REQ-004 CLK  in  1  single clock; all logic rising-edge; one clock, reset is synchronous and active-high.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 SEL  in  SW=max(1,clog2(N_SRC))  requested source index, level-sensitive.
REQ-007 SRC_BUS  in  N_SRC*50  packed per-source bundles; bundle k occupies bits [50k+49:50k] in order LED_D[8], SEG_COM[6], SEG_DATA[8], DOT_CD[10], DOT_RD[7], LCD_RS, LCD_RW, LCD_E, LCD_D[8] (MSB to LSB).
REQ-008 LED_D 8, SEG_COM 6, SEG_DATA 8, DOT_CD 10, DOT_RD 7, LCD_RS 1, LCD_RW 1, LCD_E 1, LCD_D 8  out  registered peripheral pin drives.
REQ-009 CUR_SEL  out  SW  index of source currently driving outputs.
REQ-010 BUSY  out  1  high whenever state is not ACTIVE.
REQ-011 SEL_ERR  out  1  one-cycle pulse when SEL >= N_SRC is sampled.

Function
REQ-012 Outputs SHALL be registered: in ACTIVE, pins equal bundle CUR_SEL sampled one cycle earlier (latency 1).
REQ-013 States SHALL be ACTIVE, WAIT_E, BLANK.
REQ-014 ACTIVE -> WAIT_E when valid SEL != CUR_SEL; the target is latched into NXT_SEL.
REQ-015 In WAIT_E the outgoing source SHALL keep driving the pins; transition to BLANK on the first cycle its LCD_E is 0, or after E_TIMEOUT cycles.
REQ-016 On timeout, LCD_E SHALL be forced 0 while LCD_D/RS/RW hold their last values for one cycle before entering BLANK.
REQ-017 In BLANK all pins SHALL be the idle value (all zeros) for exactly BLANK_CYC cycles, then CUR_SEL <= NXT_SEL and state -> ACTIVE.
REQ-018 A valid SEL change during WAIT_E or BLANK SHALL update NXT_SEL; in BLANK the blank counter restarts at 0.
REQ-019 SEL returning to CUR_SEL during WAIT_E SHALL abort back to ACTIVE with no blanking.
REQ-020 SEL >= N_SRC SHALL be ignored (no state change) and SHALL pulse SEL_ERR each cycle it is sampled.
REQ-021 Counters SHALL be 8 bits and saturate, never wrap.
REQ-022 Output path SHALL never combine bits of two different sources in one cycle.

Reset
REQ-023 During RST: state ACTIVE, CUR_SEL = NXT_SEL = 0, counters 0, BUSY 0, SEL_ERR 0, all pins idle (zeros).
REQ-024 First cycle after RST deassertion: pins SHALL reflect source 0; a SEL != 0 at that time SHALL start a normal switch.
REQ-025 RST asserted mid-switch SHALL abandon the switch with no further blanking.

Structure
REQ-026 Shared package periph_pkg SHALL hold the bundle width (50), field offsets/widths, and the idle bundle constant.
REQ-027 One sub-module, periph_bundle_mux (combinational N_SRC-to-1 bundle select), SHALL be instantiated; the FSM, counters and output registers stay in the top.

Verification
REQ-028 N_SRC=2, SEL=0, bundle0 LED_D=8'hA5 -> LED_D=8'hA5 one cycle later, BUSY=0.
REQ-029 SEL 0->1 with src0 LCD_E=0 -> one WAIT_E cycle, then 16 cycles of all-zero pins with BUSY=1, then bundle1 on pins, CUR_SEL=1.
REQ-030 SEL 0->1 with src0 LCD_E held 1 -> LCD_E drops after 255 cycles, then blanking, then switch.
REQ-031 N_SRC=3, SEL 0->1 then ->2 at blank cycle 10 -> blanking restarts, final CUR_SEL=2 after 16 further cycles.
REQ-032 N_SRC=3, SEL=3 for 4 cycles -> SEL_ERR high 4 cycles, outputs and CUR_SEL unchanged.
REQ-033 RST pulsed during BLANK with SEL=1 -> pins idle during reset, source 0 next cycle, then a fresh switch to 1.
